// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage.
// Owns the program counter, drives the combinational instruction memory and
// holds the fetched word in an IF/ID register with a valid/ready handshake.
// Redirects from execute take priority in every state. A misaligned or
// out-of-range PC turns into a single fault marker entry.
// Optional build macro FETCH_STATIC_PREDICT_EN: predicts backward conditional
// branches as taken and flags them on if_pred_taken.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_BYTES = 40
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_en,
  output logic [31:0] imem_pc,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic        if_fault,
  output logic        if_pred_taken,
  output logic        busy
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] pc_q;
  logic [31:0] next_pc;
  logic        pred_hit;
  logic        xfer;
  logic        load_opp;
  logic        pc_bad;
  logic        do_load;
  logic        do_fault;

  // The whole word must fit: the last byte is at pc+3. Computed in 33 bits so
  // a PC near the top of the address space cannot wrap into range.
  function automatic logic pc_faulty(input logic [31:0] pc);
    logic [32:0] last_byte;
    last_byte = {1'b0, pc} + 33'd3;
    return (pc[1:0] != 2'b00) || (last_byte >= 33'(IMEM_BYTES));
  endfunction

`ifdef FETCH_STATIC_PREDICT_EN
  // Conditional branch whose B-immediate sign bit is set (backward branch).
  function automatic logic is_back_branch(input logic [31:0] instr);
    return (instr[6:0] == 7'h63) && instr[31];
  endfunction

  function automatic logic [31:0] branch_target(input logic [31:0] pc,
                                                input logic [31:0] instr);
    logic [31:0] imm;
    imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    return pc + imm;
  endfunction
`endif

  assign xfer     = if_valid && if_ready;
  assign load_opp = (state == RUN) && (!if_valid || if_ready) && !redirect_valid;
  assign pc_bad   = pc_faulty(pc_q);
  assign do_load  = load_opp && fetch_en && !pc_bad;
  assign do_fault = load_opp && fetch_en && pc_bad;
  assign imem_pc  = pc_q;

  // Next fetch address and prediction flag for the word being loaded.
  always_comb begin
`ifdef FETCH_STATIC_PREDICT_EN
    pred_hit = is_back_branch(imem_instr);
    next_pc  = pred_hit ? branch_target(pc_q, imem_instr) : pc_q + 32'd4;
`else
    pred_hit = 1'b0;
    next_pc  = pc_q + 32'd4;
`endif
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; a redirect pre-empts everything else.
  always_comb begin
    state_nxt = state;
    if (redirect_valid) begin
      if (state == FAULT) state_nxt = RUN;
    end else begin
      case (state)
        IDLE:    if (fetch_en) state_nxt = RUN;
        RUN: begin
          if (load_opp) begin
            if (!fetch_en)   state_nxt = IDLE;
            else if (pc_bad) state_nxt = FAULT;
          end
        end
        FAULT:   state_nxt = FAULT;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // State-derived outputs.
  always_comb begin
    busy = (state != IDLE);
  end

  // PC and IF/ID register: redirect, then instruction load, then fault
  // marker, otherwise just retire the entry decode consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q     <= RESET_PC;
      if_valid <= 1'b0;
      if_pc    <= 32'h0;
      if_instr <= NOP;
      if_fault <= 1'b0;
    end else if (redirect_valid) begin
      pc_q     <= redirect_pc;
      if_valid <= 1'b0;
      if_fault <= 1'b0;
    end else if (do_load) begin
      pc_q     <= next_pc;
      if_valid <= 1'b1;
      if_pc    <= pc_q;
      if_instr <= imem_instr;
      if_fault <= 1'b0;
    end else if (do_fault) begin
      if_valid <= 1'b1;
      if_pc    <= pc_q;
      if_instr <= NOP;
      if_fault <= 1'b1;
    end else if (xfer) begin
      if_valid <= 1'b0;
    end
  end

`ifdef FETCH_STATIC_PREDICT_EN
  logic pred_q;

  // Prediction flag travels with the loaded word; fault markers carry 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        pred_q <= 1'b0;
    else if (redirect_valid) pred_q <= pred_q;
    else if (do_load)  pred_q <= pred_hit;
    else if (do_fault) pred_q <= 1'b0;
  end

  assign if_pred_taken = pred_q;
`else
  assign if_pred_taken = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed walk through the fetch scenarios followed by a
// randomized run, every cycle compared against a behavioural model.
module tb_fetch_unit;

  localparam int          MEM_BYTES = 40;
  localparam logic [31:0] NOP       = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_en;
  logic [31:0] imem_pc;
  logic [31:0] imem_instr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        if_fault;
  logic        if_pred_taken;
  logic        busy;

  logic [31:0] mem [0:15];

  fetch_unit #(.RESET_PC(32'h0), .IMEM_BYTES(MEM_BYTES)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .fetch_en       (fetch_en),
    .imem_pc        (imem_pc),
    .imem_instr     (imem_instr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_pc          (if_pc),
    .if_instr       (if_instr),
    .if_fault       (if_fault),
    .if_pred_taken  (if_pred_taken),
    .busy           (busy)
  );

  assign imem_instr = mem[imem_pc[5:2]];

  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Behavioural model: mode 0 = idle, 1 = fetching, 2 = parked on a fault.
  int          m_mode;
  logic [31:0] m_pc;
  bit          m_valid;
  logic [31:0] m_ipc;
  logic [31:0] m_instr;
  bit          m_fault;
  bit          m_pred;

  task automatic model_reset;
    m_mode = 0; m_pc = 32'h0; m_valid = 0; m_ipc = 32'h0;
    m_instr = NOP; m_fault = 0; m_pred = 0;
  endtask

  // Where the fetcher goes after word w at pc (backward branches taken only
  // when prediction is built in).
  function automatic logic [31:0] model_next(input logic [31:0] pc, input logic [31:0] w,
                                             output bit taken);
    int off;
    taken = 0;
    off   = 4;
`ifdef FETCH_STATIC_PREDICT_EN
    if (w[6:0] == 7'h63 && w[31]) begin
      taken = 1;
      off = -4096 + (w[7] ? 2048 : 0) + int'(w[30:25]) * 32 + int'(w[11:8]) * 2;
    end
`endif
    return pc + 32'(off);
  endfunction

  task automatic model_step;
    bit          consumed;
    bit          room;
    bit          bad;
    bit          tk;
    logic [31:0] w;
    consumed = m_valid && if_ready;
    room     = (m_mode == 1) && (!m_valid || if_ready);
    bad      = (m_pc % 4 != 0) || (longint'(m_pc) + 3 >= MEM_BYTES);
    if (redirect_valid) begin
      m_pc = redirect_pc; m_valid = 0; m_fault = 0;
      if (m_mode == 2) m_mode = 1;
    end else if (m_mode == 0) begin
      if (fetch_en) m_mode = 1;
      if (consumed) m_valid = 0;
    end else if (room && !fetch_en) begin
      m_mode = 0;
      if (consumed) m_valid = 0;
    end else if (room && bad) begin
      m_mode = 2; m_valid = 1; m_fault = 1; m_ipc = m_pc; m_instr = NOP; m_pred = 0;
    end else if (room) begin
      w = mem[(m_pc >> 2) & 15];
      m_valid = 1; m_fault = 0; m_ipc = m_pc; m_instr = w;
      m_pc = model_next(m_pc, w, tk);
      m_pred = tk;
    end else if (consumed) begin
      m_valid = 0;
    end
  endtask

  task automatic compare_all;
    check("imem_pc",   imem_pc,             m_pc);
    check("if_valid",  32'(if_valid),       32'(m_valid));
    check("busy",      32'(busy),           32'(m_mode != 0));
    check("if_pc",     if_pc,               m_ipc);
    check("if_instr",  if_instr,            m_instr);
    check("if_fault",  32'(if_fault),       32'(m_fault));
    check("pred",      32'(if_pred_taken),  32'(m_pred));
  endtask

  task automatic tick;
    @(posedge clk);
    model_step;
    #1;
    compare_all;
  endtask

  task automatic pulse_redirect(input logic [31:0] target);
    redirect_valid = 1; redirect_pc = target;
    tick;
    redirect_valid = 0;
  endtask

  // Assert reset between edges, check immediately, release before next edge.
  task automatic async_reset;
    #3 rst_n = 0;
    #1 model_reset;
    compare_all;
    #2 rst_n = 1;
  endtask

  initial begin
    int r;
    rst_n = 0; fetch_en = 0; if_ready = 0; redirect_valid = 0; redirect_pc = 0;
    mem[0] = 32'h0000_0033;
    mem[1] = 32'h4000_0033;
    for (int i = 2; i < 16; i++) mem[i] = 32'h0000_0033 | (i << 7);
    mem[9] = 32'h0000_0063;
    model_reset;

    #12;
    compare_all;
    check("rst_nop", if_instr, NOP);
    check("rst_busy", 32'(busy), 32'd0);

    rst_n = 1; fetch_en = 1; if_ready = 1;
    tick;
    check("idle_to_run_busy", 32'(busy), 32'd1);
    tick;
    check("seq_pc0", if_pc, 32'h0);
    check("seq_instr0", if_instr, 32'h0000_0033);
    tick;
    check("seq_pc4", if_pc, 32'h4);
    check("seq_instr4", if_instr, 32'h4000_0033);
    tick;
    check("seq_pc8", if_pc, 32'h8);

    if_ready = 0;
    repeat (3) tick;
    check("stall_pc", if_pc, 32'h8);
    check("stall_imem_pc", imem_pc, 32'hC);
    check("stall_valid", 32'(if_valid), 32'd1);
    if_ready = 1;
    tick;
    check("release_pc12", if_pc, 32'hC);
    tick;
    check("pend_pc16", if_pc, 32'h10);

    pulse_redirect(32'h24);
    check("redir_bubble", 32'(if_valid), 32'd0);
    tick;
    check("redir_pc", if_pc, 32'h24);
    check("redir_instr", if_instr, 32'h0000_0063);
    tick;
    check("range_fault", 32'(if_fault), 32'd1);
    check("range_fault_pc", if_pc, 32'd40);
    tick;
    check("fault_no_load", 32'(if_valid), 32'd0);

    pulse_redirect(32'h6);
    tick;
    check("misalign_fault", 32'(if_fault), 32'd1);
    check("misalign_pc", if_pc, 32'h6);
    tick;
    tick;
    check("fault_parked", 32'(if_valid), 32'd0);
    pulse_redirect(32'h0);
    tick;
    check("resume_pc0", if_pc, 32'h0);
    check("resume_nofault", 32'(if_fault), 32'd0);

    async_reset;
    check("async_valid", 32'(if_valid), 32'd0);
    check("async_nop", if_instr, NOP);
    tick;
    tick;
    check("after_rst_pc", if_pc, 32'h0);

`ifdef FETCH_STATIC_PREDICT_EN
    mem[2] = 32'hFE00_0EE3;
    pulse_redirect(32'h8);
    tick;
    check("pred_taken", 32'(if_pred_taken), 32'd1);
    check("pred_at_pc8", if_pc, 32'h8);
    tick;
    check("pred_target", if_pc, 32'h4);
`endif

    for (int i = 0; i < 16; i++) begin
      mem[i] = $urandom;
      if ($urandom_range(3) == 0) mem[i][6:0] = 7'h63;
    end

    for (int cyc = 0; cyc < 3000; cyc++) begin
      if_ready = ($urandom_range(9) < 7);
      fetch_en = ($urandom_range(15) != 0);
      redirect_valid = ($urandom_range(19) == 0);
      r = $urandom_range(7);
      if (r < 6)       redirect_pc = 32'($urandom_range(9)) * 4;
      else if (r == 6) redirect_pc = 32'($urandom_range(39));
      else             redirect_pc = 32'($urandom_range(32, 48)) & ~32'h3;
      tick;
      if ($urandom_range(299) == 0) async_reset;
    end
    redirect_valid = 0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the combinational instruction memory and the decoder.
- Owns the program counter and drives the memory byte address.
- Captures the returned 32-bit word into an IF/ID output register, with a valid/ready handshake towards decode.
- Handles branch/jump redirects from execute, and detects fetch faults (misaligned or out-of-range PC).

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- IMEM_BYTES, 40, instruction memory size in bytes; a PC with PC+3 >= IMEM_BYTES is out of range.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- fetch_en  input  1  level; allows leaving IDLE and continuing fetch.
- imem_pc  output  32  byte address to instruction memory; equals pc_q.
- imem_instr  input  32  instruction word, valid combinationally in the same cycle as imem_pc.
- redirect_valid  input  1  one-cycle pulse from execute.
- redirect_pc  input  32  redirect target.
- if_valid  output  1  IF/ID register holds an instruction.
- if_ready  input  1  decode accepts this cycle.
- if_pc  output  32  PC of the held instruction.
- if_instr  output  32  held instruction word.
- if_fault  output  1  held entry is a fault marker, not an instruction.
- if_pred_taken  output  1  static prediction flag (0 when the feature is disabled).
- busy  output  1  state != IDLE.

Behaviour:
- Reset is asynchronous, active-low, and applies when rst_n=0.
  - pc_q=RESET_PC, state=IDLE.
  - if_valid=0, if_pc=0, if_instr=32'h0000_0013 (NOP), if_fault=0, if_pred_taken=0, busy=0.
- Transfer rule: a transfer occurs on an edge where if_valid && if_ready.
- Load condition: load = (state==RUN) && (!if_valid || if_ready) && !redirect_valid.
- States:
  - IDLE: nothing is fetched. Go to RUN when fetch_en=1.
  - RUN: on load, if_pc<=pc_q, if_instr<=imem_instr, if_valid<=1, pc_q<=next_pc.
    - next_pc = pc_q+4 (32-bit wrap).
    - If fetch_en=0 at a load opportunity, no load occurs and the state goes to IDLE. pc_q and the output register are retained.
  - FAULT: entered when a load opportunity finds pc_q[1:0]!=0 or pc_q+3 >= IMEM_BYTES.
    - Instead of an instruction, load if_valid=1, if_fault=1, if_pc=pc_q, if_instr=NOP.
    - pc_q is held.
    - No further loads occur; only a redirect leaves FAULT, going to RUN.
- Redirect: redirect_valid has highest priority in every state.
  - Next edge: pc_q<=redirect_pc, if_valid<=0, if_fault<=0.
  - No load occurs in the redirect cycle, so the first fetch from the target is valid 2 edges after the pulse.
  - A transfer in the same cycle as the redirect still counts as consumed by decode.
  - A redirect in IDLE updates pc_q and the state stays IDLE.
- Backpressure: while if_valid && !if_ready, every output is stable and pc_q is held. imem_pc stays valid, and re-reading the same address is harmless.
- Misalignment is checked on pc_q at load time, not at the redirect, so a misaligned target faults one cycle later.
- Throughput: one instruction per cycle while if_ready=1.

Optional Feature:
- Macro: FETCH_STATIC_PREDICT_EN.
- Defined:
  - If imem_instr[6:0]==7'h63 (branch) and the B-immediate is negative (imem_instr[31]=1), then next_pc = pc_q + sext({instr[31],instr[7],instr[30:25],instr[11:8],1'b0}) and if_pred_taken<=1.
  - Otherwise next_pc = pc_q+4 and if_pred_taken<=0.
  - The execute stage issues a redirect on a mispredict.
- Undefined: next_pc is always pc_q+4 and if_pred_taken is tied to 0.

Test Plan:
- Reset, then fetch_en=1, if_ready=1 -> if_pc 0,4,8,... one per cycle. For a memory holding 0x00000033 and 0x40000033, if_instr=0x00000033 then 0x40000033.
- Hold if_ready=0 for 3 cycles with if_valid=1 at if_pc=8 -> if_pc, if_instr and imem_pc stable. Release -> if_pc=8 transfers, then if_pc=12.
- redirect_valid with redirect_pc=32'h24 while if_pc=16 is pending -> if_valid=0 next cycle, then if_pc=0x24 with if_instr=0x00000063. The pc_q+3 check passes because 39 < 40.
- redirect_pc=32'h6 -> one entry with if_fault=1, if_pc=6. No further loads; a redirect to 0 resumes at if_pc=0.
- Sequential fetch reaching pc=40 with IMEM_BYTES=40 -> fault entry with if_pc=40.
- rst_n low mid-stream (asynchronous, between edges) -> outputs go to their reset values immediately. After release and fetch_en=1, first if_pc=RESET_PC.
- With FETCH_STATIC_PREDICT_EN: 0xFE000EE3 (beq, imm -4) fetched at pc 8 -> if_pred_taken=1, next if_pc=4.
